// File: rtl/lcompressor_dyn.sv
// lcompressor_dyn: feed-forward dynamic-range compressor/limiter for signed PCM.
//
// A three-stage pipeline, fixed latency 3:
//   S1 captures the sample, its sign and saturated magnitude, and the per-sample
//      controls (threshold, ratio, bypass).
//   S2 updates the peak envelope (shift-based attack/release).
//   S3 derives the gain reduction from the updated envelope and applies it in
//      the magnitude domain, then restores the sign.
//
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_valid    sample strobe (no backpressure)
//   i_data     signed input sample, DATA_W bits
//   i_thresh   unsigned threshold magnitude, DATA_W-1 bits
//   i_ratio    0..6 -> 2^r:1 ratio, 7 -> hard limiter
//   i_bypass   pass the sample unmodified, same latency
//   o_valid    output strobe
//   o_data     signed output sample (held while o_valid=0)
//   o_env      current envelope (unsigned)
//   o_gr       gain reduction applied to o_data (held while o_valid=0)
module lcompressor_dyn #(
  parameter int DATA_W     = 16,
  parameter int ATTACK_SH  = 2,
  parameter int RELEASE_SH = 6
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-2:0] i_thresh,
  input  logic [2:0]        i_ratio,
  input  logic              i_bypass,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [DATA_W-2:0] o_env,
  output logic [DATA_W-2:0] o_gr
);

  localparam int MW = DATA_W - 1;

  // |x| with the most-negative value saturated to the largest positive magnitude.
  function automatic logic [MW-1:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1]) begin
      abs_sat = x[MW-1:0];
    end else if (neg[DATA_W-1]) begin
      abs_sat = {MW{1'b1}};
    end else begin
      abs_sat = neg[MW-1:0];
    end
  endfunction

  // S1 registers
  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [MW-1:0]     s1_mag_q;
  logic [DATA_W-1:0] s1_raw_q;
  logic [MW-1:0]     s1_thr_q;
  logic [2:0]        s1_ratio_q;
  logic              s1_byp_q;

  // S2 registers
  logic              s2_valid_q;
  logic              s2_sign_q;
  logic [MW-1:0]     s2_mag_q;
  logic [DATA_W-1:0] s2_raw_q;
  logic [MW-1:0]     s2_thr_q;
  logic [2:0]        s2_ratio_q;
  logic              s2_byp_q;
  logic [MW-1:0]     env_q, env_d;

  // S3 / output registers
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [MW-1:0]     out_gr_q, out_gr_d;

  logic [MW-1:0]     excess_s, red_s, out_mag_s;
  logic [DATA_W-1:0] out_mag_ext_s;

  // S1: capture sample and per-sample controls
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_raw_q   <= '0;
      s1_thr_q   <= '0;
      s1_ratio_q <= 3'd0;
      s1_byp_q   <= 1'b0;
    end else begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sign_q  <= i_data[DATA_W-1];
        s1_mag_q   <= abs_sat(i_data);
        s1_raw_q   <= i_data;
        s1_thr_q   <= i_thresh;
        s1_ratio_q <= i_ratio;
        s1_byp_q   <= i_bypass;
      end
    end
  end

  // Envelope next state: move toward the magnitude by a shifted fraction of the gap.
  // Both directions stay within [min(env,mag), max(env,mag)], so no overflow.
  always_comb begin
    env_d = env_q;
    if (s1_valid_q) begin
      if (s1_mag_q > env_q) begin
        env_d = env_q + ((s1_mag_q - env_q) >> ATTACK_SH);
      end else begin
        env_d = env_q - ((env_q - s1_mag_q) >> RELEASE_SH);
      end
    end else begin
      env_d = env_q;
    end
  end

  // S2: envelope update and pipeline forwarding
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_mag_q   <= '0;
      s2_raw_q   <= '0;
      s2_thr_q   <= '0;
      s2_ratio_q <= 3'd0;
      s2_byp_q   <= 1'b0;
      env_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      env_q      <= env_d;
      if (s1_valid_q) begin
        s2_sign_q  <= s1_sign_q;
        s2_mag_q   <= s1_mag_q;
        s2_raw_q   <= s1_raw_q;
        s2_thr_q   <= s1_thr_q;
        s2_ratio_q <= s1_ratio_q;
        s2_byp_q   <= s1_byp_q;
      end
    end
  end

  // S3: gain reduction from the already-updated envelope, applied to magnitude
  always_comb begin
    excess_s = (env_q > s2_thr_q) ? (env_q - s2_thr_q) : '0;
    case (s2_ratio_q)
      3'd7:    red_s = excess_s;
      // r=0 gives excess-excess=0, i.e. 1:1
      default: red_s = excess_s - (excess_s >> s2_ratio_q);
    endcase
    // Clip at zero rather than wrapping, so the sign can never flip.
    out_mag_s     = (s2_mag_q > red_s) ? (s2_mag_q - red_s) : '0;
    out_mag_ext_s = {1'b0, out_mag_s};
    if (s2_byp_q) begin
      out_data_d = s2_raw_q;
      out_gr_d   = '0;
    end else begin
      out_data_d = s2_sign_q ? -out_mag_ext_s : out_mag_ext_s;
      out_gr_d   = red_s;
    end
  end

  // Output register: data and gain reduction hold between valid samples
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_gr_q    <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= out_data_d;
        out_gr_q   <= out_gr_d;
      end
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_gr    = out_gr_q;
  assign o_env   = env_q;

endmodule
